spectrum_bank: RTL and testbench



---
 rtl/spectrum_bank_if.sv | 12 +
 rtl/spectrum_bank.sv | 179 +++++++++++++++++
 tb/tb_spectrum_bank.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/spectrum_bank_if.sv
// spectrum_bank_if: byte stream from the UART receiver into spectrum_bank.
//   rx_valid : one-cycle strobe, rx_data holds a received byte
//   rx_data  : received byte (bit 7 = header flag, bits 6:0 = index/value)
// master : the UART receiver side (drives the byte stream)
// slave  : spectrum_bank side (consumes the byte stream)
interface spectrum_bank_if;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (output rx_valid, output rx_data);
  modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/spectrum_bank.sv
// spectrum_bank: parses {band header, amplitude} byte pairs from the UART
// receiver into a per-band amplitude register file and drives a band-activity
// vector for the display logic.
//
// Ports:
//   clk       : system clock
//   rstn      : synchronous active-low reset
//   rx        : byte stream (spectrum_bank_if.slave: rx_valid, rx_data)
//   rd_band   : readback band select
//   rd_amp    : stored amplitude of rd_band, registered (0 if out of range)
//   rd_peak   : peak-hold value of rd_band, registered
//   band_on   : bit i set while amp[i] != 0
//   upd       : one-cycle pulse, a band was written
//   upd_band  : band written, valid with upd
//   frame_err : one-cycle pulse on a protocol error or inter-byte timeout
//
// Optional feature macro: SPECTRUM_PEAK_HOLD_EN
//   defined   : per-band peak-hold, decaying one step every DECAY_CYC cycles
//   undefined : no peak storage; rd_peak mirrors rd_amp
module spectrum_bank #(
  parameter  int NBANDS      = 16,
  parameter  int AMP_W       = 4,
  parameter  int AMP_MAX     = 10,
  parameter  int TIMEOUT_CYC = 12500,
  parameter  int DECAY_CYC   = 1200000,
  localparam int BW          = $clog2(NBANDS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  spectrum_bank_if.slave        rx,
  input  logic [BW-1:0]         rd_band,
  output logic [AMP_W-1:0]      rd_amp,
  output logic [AMP_W-1:0]      rd_peak,
  output logic [NBANDS-1:0]     band_on,
  output logic                  upd,
  output logic [BW-1:0]         upd_band,
  output logic                  frame_err
);

  localparam int               TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AMP_W-1:0] AMP_CAP  = AMP_W'(AMP_MAX);

  if (NBANDS < 2 || NBANDS > 128 || AMP_MAX < 0 || AMP_MAX > (1 << AMP_W) - 1 ||
      TIMEOUT_CYC < 1 || DECAY_CYC < 1) begin : g_cfg_err
    $error("spectrum_bank: parameter out of range");
  end

  typedef enum logic {IDLE, WAIT_DATA} state_t;

  state_t           state;
  logic [BW-1:0]    idx_q;
  logic [TW-1:0]    tmo_cnt;
  logic [AMP_W-1:0] amp [NBANDS];

  logic             is_hdr;
  logic [6:0]       byte_val;
  logic             hdr_ok;
  logic [AMP_W-1:0] sat_val;
  logic             wr_en;
  logic             rd_in_range;

  assign is_hdr      = rx.rx_data[7];
  assign byte_val    = rx.rx_data[6:0];
  assign hdr_ok      = {25'd0, byte_val} < NBANDS;
  assign sat_val     = ({25'd0, byte_val} > AMP_MAX) ? AMP_CAP : AMP_W'(byte_val);
  // A data byte completes a frame only while a header is pending.
  assign wr_en       = (state == WAIT_DATA) && rx.rx_valid && !is_hdr;
  assign rd_in_range = 32'(rd_band) < NBANDS;

  // Frame parser. A received byte always takes priority over the timeout.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      idx_q     <= '0;
      tmo_cnt   <= '0;
      upd       <= 1'b0;
      upd_band  <= '0;
      frame_err <= 1'b0;
    end else begin
      upd       <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx.rx_valid) begin
            if (is_hdr && hdr_ok) begin
              idx_q   <= byte_val[BW-1:0];
              tmo_cnt <= '0;
              state   <= WAIT_DATA;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          if (rx.rx_valid) begin
            if (!is_hdr) begin
              upd      <= 1'b1;
              upd_band <= idx_q;
              state    <= IDLE;
            end else begin
              // Header while waiting for data: flag it, resync on a valid one.
              frame_err <= 1'b1;
              if (hdr_ok) begin
                idx_q   <= byte_val[BW-1:0];
                tmo_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Amplitude register file and activity vector.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NBANDS; i++) amp[i] <= '0;
      band_on <= '0;
    end else if (wr_en) begin
      amp[idx_q]     <= sat_val;
      band_on[idx_q] <= |sat_val;
    end
  end

  // Registered readback; sees the pre-write value on a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rstn) rd_amp <= '0;
    else       rd_amp <= rd_in_range ? amp[rd_band] : '0;
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam int            DW       = $clog2(DECAY_CYC + 1);
  localparam logic [DW-1:0] DCY_LAST = DW'(DECAY_CYC - 1);

  logic [DW-1:0]    dcy_cnt;
  logic             dcy_tick;
  logic [AMP_W-1:0] peak [NBANDS];

  assign dcy_tick = (dcy_cnt == DCY_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) dcy_cnt <= '0;
    else       dcy_cnt <= dcy_tick ? '0 : dcy_cnt + 1'b1;
  end

  // A write to a band suppresses that band's decay step in the same cycle.
  // Decay only runs while peak > amp, so peak never drops below amp.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NBANDS; i++) peak[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NBANDS; i++) begin
        if (wr_en && idx_q == BW'(i)) begin
          if (sat_val > peak[i]) peak[i] <= sat_val;
        end else if (dcy_tick && peak[i] > amp[i]) begin
          peak[i] <= peak[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) rd_peak <= '0;
    else       rd_peak <= rd_in_range ? peak[rd_band] : '0;
  end
`else
  assign rd_peak = rd_amp;
`endif

endmodule

// File: tb/tb_spectrum_bank.sv
// tb_spectrum_bank: directed frames plus randomized byte traffic for
// spectrum_bank, checked every cycle against a frame-level model.
module tb_spectrum_bank;
  localparam int NBANDS  = 16;
  localparam int AMP_W   = 4;
  localparam int AMP_MAX = 10;
  localparam int TMO     = 12500;
  localparam int DECAY   = 8;
  localparam int BW      = $clog2(NBANDS);

  logic              clk;
  logic              rstn;
  logic [BW-1:0]     rd_band;
  logic [AMP_W-1:0]  rd_amp;
  logic [AMP_W-1:0]  rd_peak;
  logic [NBANDS-1:0] band_on;
  logic              upd;
  logic [BW-1:0]     upd_band;
  logic              frame_err;

  spectrum_bank_if rx_if ();

  spectrum_bank #(
    .NBANDS(NBANDS), .AMP_W(AMP_W), .AMP_MAX(AMP_MAX),
    .TIMEOUT_CYC(TMO), .DECAY_CYC(DECAY)
  ) dut (
    .clk(clk), .rstn(rstn), .rx(rx_if.slave), .rd_band(rd_band),
    .rd_amp(rd_amp), .rd_peak(rd_peak), .band_on(band_on),
    .upd(upd), .upd_band(upd_band), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_amp  [NBANDS];
  int     m_peak [NBANDS];
  int     m_pend;          // band awaiting its data byte, -1 when none
  int     m_idle;          // idle cycles since that header
  longint m_edges;         // clock edges since reset released
  int     e_rd_amp, e_rd_peak, e_upd, e_upd_band, e_err;
  bit     started = 0;

  always @(posedge clk) begin : model
    int v, a, wrote, rd_a, rd_p;
    bit decay;
    started = 1;
    if (!rstn) begin
      for (int i = 0; i < NBANDS; i++) begin m_amp[i] = 0; m_peak[i] = 0; end
      m_pend = -1; m_idle = 0; m_edges = 0;
      e_rd_amp = 0; e_rd_peak = 0; e_upd = 0; e_upd_band = 0; e_err = 0;
    end else begin
      rd_a = (int'(rd_band) < NBANDS) ? m_amp[rd_band] : 0;
`ifdef SPECTRUM_PEAK_HOLD_EN
      rd_p = (int'(rd_band) < NBANDS) ? m_peak[rd_band] : 0;
`else
      rd_p = rd_a;
`endif
      decay = (m_edges % DECAY) == DECAY - 1;
      m_edges++;
      e_upd = 0; e_err = 0; wrote = -1;
      if (rx_if.rx_valid) begin
        v = int'(rx_if.rx_data[6:0]);
        if (rx_if.rx_data[7]) begin
          if (m_pend >= 0 || v >= NBANDS) e_err = 1;
          if (v < NBANDS) begin m_pend = v; m_idle = 0; end
          else m_pend = -1;
        end else if (m_pend < 0) begin
          e_err = 1;
        end else begin
          a = (v > AMP_MAX) ? AMP_MAX : v;
          m_amp[m_pend] = a;
          if (a > m_peak[m_pend]) m_peak[m_pend] = a;
          e_upd = 1; e_upd_band = m_pend; wrote = m_pend;
          m_pend = -1;
        end
      end else if (m_pend >= 0) begin
        m_idle++;
        if (m_idle == TMO) begin e_err = 1; m_pend = -1; end
      end
      if (decay)
        for (int i = 0; i < NBANDS; i++)
          if (i != wrote && m_peak[i] > m_amp[i]) m_peak[i]--;
      e_rd_amp = rd_a; e_rd_peak = rd_p;
    end
  end

  always @(negedge clk) begin : compare
    logic [NBANDS-1:0] e_on;
    if (started) begin
      for (int i = 0; i < NBANDS; i++) e_on[i] = (m_amp[i] != 0);
      check("rd_amp",    64'(rd_amp),    64'(e_rd_amp));
      check("rd_peak",   64'(rd_peak),   64'(e_rd_peak));
      check("band_on",   64'(band_on),   64'(e_on));
      check("upd",       64'(upd),       64'(e_upd));
      check("frame_err", 64'(frame_err), 64'(e_err));
      if (e_upd != 0) check("upd_band", 64'(upd_band), 64'(e_upd_band));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = b;
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; rd_band = '0;
    rx_if.rx_valid = 1'b0; rx_if.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset band_on", 64'(band_on), 64'h0);
    check("reset rd_amp",  64'(rd_amp),  64'h0);
    check("reset upd",     64'(upd),     64'h0);
    check("reset err",     64'(frame_err), 64'h0);
    rstn = 1'b1;

    // basic frame
    send_byte(8'h83); check("hdr no err", 64'(frame_err), 64'h0);
    send_byte(8'h07);
    check("t1 upd", 64'(upd), 64'h1);
    check("t1 upd_band", 64'(upd_band), 64'h3);
    check("t1 band_on", 64'(band_on), 64'h0008);
    rd_band = 4'd3; tick();
    check("t1 rd_amp", 64'(rd_amp), 64'h7);
    check("t1 upd pulse", 64'(upd), 64'h0);

    // saturation and zero write
    send_byte(8'h85); send_byte(8'h7F);
    rd_band = 4'd5; tick();
    check("t2 sat", 64'(rd_amp), 64'd10);
    send_byte(8'h85); send_byte(8'h00);
    check("t2 band_on", 64'(band_on), 64'h0008);

    // stray data and bad header
    send_byte(8'h12);
    check("t3 data err", 64'(frame_err), 64'h1);
    check("t3 no upd", 64'(upd), 64'h0);
    send_byte(8'h90);
    check("t3 idx err", 64'(frame_err), 64'h1);

    // inter-byte timeout
    send_byte(8'h82);
    repeat (TMO - 1) tick();
    check("t4 pre-timeout", 64'(frame_err), 64'h0);
    tick();
    check("t4 timeout", 64'(frame_err), 64'h1);
    send_byte(8'h04);
    check("t4 late data err", 64'(frame_err), 64'h1);
    rd_band = 4'd2; tick();
    check("t4 amp2", 64'(rd_amp), 64'h0);

    // header restart
    send_byte(8'h81); send_byte(8'h86);
    check("t5 restart err", 64'(frame_err), 64'h1);
    send_byte(8'h09);
    check("t5 upd_band", 64'(upd_band), 64'h6);
    rd_band = 4'd6; tick();
    check("t5 amp6", 64'(rd_amp), 64'h9);
    rd_band = 4'd1; tick();
    check("t5 amp1", 64'(rd_amp), 64'h0);

    // reset mid-frame
    send_byte(8'h84);
    rstn = 1'b0; tick();
    check("t5 rst band_on", 64'(band_on), 64'h0);
    check("t5 rst rd_amp", 64'(rd_amp), 64'h0);
    rstn = 1'b1;
    send_byte(8'h05);
    check("t5 post-rst err", 64'(frame_err), 64'h1);
    check("t5 post-rst upd", 64'(upd), 64'h0);

    // peak hold
    send_byte(8'h80); send_byte(8'h09);
    send_byte(8'h80); send_byte(8'h02);
    rd_band = 4'd0; tick();
    check("t6 amp", 64'(rd_amp), 64'h2);
`ifdef SPECTRUM_PEAK_HOLD_EN
    check("t6 peak held", 64'(rd_peak), 64'h9);
    repeat (80) tick();
    check("t6 peak decayed", 64'(rd_peak), 64'h2);
`else
    check("t6 peak mirror", 64'(rd_peak), 64'h2);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      rd_band = BW'($urandom_range(0, NBANDS - 1));
      if (r < 1) begin
        rstn = 1'b0; tick(); rstn = 1'b1;
      end else if (r < 10) begin
        repeat ($urandom_range(1, 5)) tick();
      end else if (r < 50) begin
        send_byte({1'b1, 7'($urandom_range(0, NBANDS - 1))});
      end else if (r < 55) begin
        send_byte({1'b1, 7'($urandom_range(NBANDS, 127))});
      end else begin
        send_byte({1'b0, 7'($urandom_range(0, 127))});
      end
    end
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
